// File: rtl/branch_predictor_if.sv
// Fetch/decode-side bundle between the controller and the branch predictor.
// Master drives fetch PC, F->D control and training; slave returns predictions.
interface bp_if;
    logic [31:0] pc_f;
    logic        pred_f;
    logic [31:0] pred_target_f;
    logic        stall_d;
    logic        flush_d;
    logic        pred_d;
    logic        update_en;
    logic        taken_d;
    logic [31:0] target_d;

    modport master (
        output pc_f, stall_d, flush_d, update_en, taken_d, target_d,
        input  pred_f, pred_target_f, pred_d
    );

    modport slave (
        input  pc_f, stall_d, flush_d, update_en, taken_d, target_d,
        output pred_f, pred_target_f, pred_d
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter + tagged target predictor; optional gshare indexing via BRANCH_PREDICTOR_GSHARE_EN.
// Latency: lookup combinational, pred_d one cycle later, training visible the cycle after update_en.
// Backpressure: stall_d holds the F->D prediction register, flush_d clears it (flush wins).
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic clk,
    input  logic reset,
    bp_if.slave  bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    typedef logic [INDEX_BITS-1:0] idx_t;
    typedef logic [TAG_BITS-1:0]   tag_t;

    typedef struct packed {
        logic        valid;
        tag_t        tag;
        logic [1:0]  ctr;
        logic [31:0] target;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, ctr: 2'b01, target: 32'd0};

    entry_t table_q [ENTRIES];

    idx_t   idx_f;
    tag_t   tag_f;
    entry_t ent_f;
    logic   hit_f;
    logic   pred_f;

    logic   fd_pred_q, fd_pred_d;
    idx_t   fd_idx_q,  fd_idx_d;
    tag_t   fd_tag_q,  fd_tag_d;

    entry_t upd_ent;
    entry_t upd_next;
    logic   upd_hit;
    logic   upd_wr;

    logic   unused_pc_bits;
    assign unused_pc_bits = ^{bp.pc_f[1:0], bp.pc_f >> (INDEX_BITS + TAG_BITS + 2)};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    idx_t ghr_q, ghr_d;

    always_comb begin
        ghr_d = ghr_q;
        if (bp.update_en) begin
            ghr_d = {ghr_q[INDEX_BITS-2:0], bp.taken_d};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    always_comb idx_f = bp.pc_f[INDEX_BITS+1:2] ^ ghr_q;
`else
    always_comb idx_f = bp.pc_f[INDEX_BITS+1:2];
`endif

    // Lookup reads pre-update state; no bypass from a same-cycle train.
    always_comb begin
        tag_f  = bp.pc_f[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
        ent_f  = table_q[idx_f];
        hit_f  = ent_f.valid && (ent_f.tag == tag_f);
        pred_f = hit_f && ent_f.ctr[1];
    end

    assign bp.pred_f        = pred_f;
    assign bp.pred_target_f = pred_f ? ent_f.target : bp.pc_f + 32'd4;
    assign bp.pred_d        = fd_pred_q;

    always_comb begin
        fd_pred_d = fd_pred_q;
        fd_idx_d  = fd_idx_q;
        fd_tag_d  = fd_tag_q;
        if (bp.flush_d) begin
            fd_pred_d = 1'b0;
            fd_idx_d  = '0;
            fd_tag_d  = '0;
        end else if (!bp.stall_d) begin
            fd_pred_d = pred_f;
            fd_idx_d  = idx_f;
            fd_tag_d  = tag_f;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fd_pred_q <= 1'b0;
            fd_idx_q  <= '0;
            fd_tag_q  <= '0;
        end else begin
            fd_pred_q <= fd_pred_d;
            fd_idx_q  <= fd_idx_d;
            fd_tag_q  <= fd_tag_d;
        end
    end

    // Training always targets the entry captured at fetch, never a recomputed index.
    always_comb begin
        upd_ent  = table_q[fd_idx_q];
        upd_next = upd_ent;
        upd_hit  = upd_ent.valid && (upd_ent.tag == fd_tag_q);
        upd_wr   = 1'b0;
        if (bp.update_en) begin
            if (upd_hit) begin
                upd_wr = 1'b1;
                if (bp.taken_d) begin
                    if (upd_ent.ctr != 2'b11) begin
                        upd_next.ctr = upd_ent.ctr + 2'd1;
                    end
                    upd_next.target = bp.target_d;
                end else if (upd_ent.ctr != 2'b00) begin
                    upd_next.ctr = upd_ent.ctr - 2'd1;
                end
            end else if (bp.taken_d) begin
                upd_wr          = 1'b1;
                upd_next.valid  = 1'b1;
                upd_next.tag    = fd_tag_q;
                upd_next.ctr    = 2'b10;
                upd_next.target = bp.target_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= RESET_ENTRY;
            end
        end else if (upd_wr) begin
            table_q[fd_idx_q] <= upd_next;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Randomized + directed bench for branch_predictor against an array-based reference model.
module tb_branch_predictor;
    localparam int IB = 6;
    localparam int TB = 8;
    localparam int N  = 1 << IB;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bp_if bp();

    branch_predictor #(.INDEX_BITS(IB), .TAG_BITS(TB)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model state
    bit          m_valid  [N];
    int          m_tag    [N];
    int          m_ctr    [N];
    logic [31:0] m_target [N];
    bit          m_pred_d;
    int          m_idx_d;
    int          m_tag_d;
    int          m_ghr;

    function automatic int m_index(logic [31:0] pc);
        int i;
        i = int'((pc >> 2) % N);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        i = i ^ m_ghr;
`endif
        return i;
    endfunction

    function automatic int m_tagof(logic [31:0] pc);
        return int'((pc >> (IB + 2)) % (1 << TB));
    endfunction

    function automatic bit m_pred(logic [31:0] pc);
        int i;
        i = m_index(pc);
        return m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(logic [31:0] pc);
        return m_pred(pc) ? m_target[m_index(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_ctr[i]    = 1;
            m_target[i] = 32'd0;
        end
        m_pred_d = 1'b0;
        m_idx_d  = 0;
        m_tag_d  = 0;
        m_ghr    = 0;
    endtask

    task automatic check32(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Model advances on the same edge as the DUT using pre-edge inputs.
    bit mp_pred;
    int mp_idx;
    int mp_tag;
    bit mp_hit;
    always @(posedge clk) begin
        if (reset) begin
            m_reset();
        end else begin
            mp_pred = m_pred(bp.pc_f);
            mp_idx  = m_index(bp.pc_f);
            mp_tag  = m_tagof(bp.pc_f);
            if (bp.update_en) begin
                mp_hit = m_valid[m_idx_d] && (m_tag[m_idx_d] == m_tag_d);
                if (mp_hit) begin
                    if (bp.taken_d) begin
                        m_ctr[m_idx_d]    = (m_ctr[m_idx_d] < 3) ? m_ctr[m_idx_d] + 1 : 3;
                        m_target[m_idx_d] = bp.target_d;
                    end else begin
                        m_ctr[m_idx_d] = (m_ctr[m_idx_d] > 0) ? m_ctr[m_idx_d] - 1 : 0;
                    end
                end else if (bp.taken_d) begin
                    m_valid[m_idx_d]  = 1'b1;
                    m_tag[m_idx_d]    = m_tag_d;
                    m_ctr[m_idx_d]    = 2;
                    m_target[m_idx_d] = bp.target_d;
                end
                m_ghr = ((m_ghr << 1) | int'(bp.taken_d)) % N;
            end
            if (bp.flush_d) begin
                m_pred_d = 1'b0;
                m_idx_d  = 0;
                m_tag_d  = 0;
            end else if (!bp.stall_d) begin
                m_pred_d = mp_pred;
                m_idx_d  = mp_idx;
                m_tag_d  = mp_tag;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            check32("model_pred_f", {31'd0, bp.pred_f}, {31'd0, m_pred(bp.pc_f)});
            check32("model_pred_target_f", bp.pred_target_f, m_ptgt(bp.pc_f));
            check32("model_pred_d", {31'd0, bp.pred_d}, {31'd0, m_pred_d});
        end
    end

    task automatic cyc(input logic [31:0] pc, input bit up, input bit tk, input logic [31:0] tg,
                       input bit st, input bit fl, input bit rs);
        @(negedge clk);
        bp.pc_f      = pc;
        bp.update_en = up;
        bp.taken_d   = tk;
        bp.target_d  = tg;
        bp.stall_d   = st;
        bp.flush_d   = fl;
        reset        = rs;
        #2;
    endtask

    initial begin
        reset        = 1'b1;
        bp.pc_f      = 32'd0;
        bp.update_en = 1'b0;
        bp.taken_d   = 1'b0;
        bp.target_d  = 32'd0;
        bp.stall_d   = 1'b0;
        bp.flush_d   = 1'b0;
        m_reset();
        cyc(32'h0, 0, 0, 32'h0, 0, 0, 1);
        cyc(32'h0, 0, 0, 32'h0, 0, 0, 1);
        chk_en = 1'b1;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
        cyc(32'h40, 0, 0, 32'h0, 0, 0, 0);
        check32("gs_reset_pred_f", {31'd0, bp.pred_f}, 32'd0);
        cyc(32'h40, 1, 1, 32'h80, 0, 0, 0);
        cyc(32'h40, 0, 0, 32'h0, 0, 0, 0);
        check32("gs_idx17_pred_f", {31'd0, bp.pred_f}, 32'd0);
        check32("gs_idx17_target", bp.pred_target_f, 32'h44);
        cyc(32'h40, 0, 1, 32'h0, 0, 0, 0);
        cyc(32'h40, 0, 0, 32'h0, 0, 0, 0);
        check32("gs_ghr_hold_pred_f", {31'd0, bp.pred_f}, 32'd0);
`else
        cyc(32'h40, 0, 0, 32'h0, 0, 0, 0);
        check32("reset_pred_f", {31'd0, bp.pred_f}, 32'd0);
        check32("reset_target", bp.pred_target_f, 32'h44);
        cyc(32'h40, 1, 1, 32'h80, 0, 0, 0);
        check32("reset_pred_d", {31'd0, bp.pred_d}, 32'd0);
        check32("no_bypass_pred_f", {31'd0, bp.pred_f}, 32'd0);
        cyc(32'h40, 0, 0, 32'h0, 0, 0, 0);
        check32("alloc_pred_f", {31'd0, bp.pred_f}, 32'd1);
        check32("alloc_target", bp.pred_target_f, 32'h80);
        cyc(32'h40, 1, 0, 32'h0, 0, 0, 0);
        check32("loaded_pred_d", {31'd0, bp.pred_d}, 32'd1);
        cyc(32'h40, 1, 0, 32'h0, 0, 0, 0);
        check32("weak_nt_pred_f", {31'd0, bp.pred_f}, 32'd0);
        cyc(32'h40, 0, 0, 32'h0, 0, 0, 0);
        check32("strong_nt_pred_f", {31'd0, bp.pred_f}, 32'd0);
        cyc(32'h40, 1, 1, 32'h80, 0, 0, 0);
        cyc(32'h40, 1, 1, 32'h80, 0, 0, 0);
        cyc(32'h40, 1, 1, 32'h80, 0, 0, 0);
        check32("weak_t_pred_f", {31'd0, bp.pred_f}, 32'd1);
        cyc(32'h40, 1, 1, 32'h80, 0, 0, 0);
        cyc(32'h40, 1, 0, 32'h0, 0, 0, 0);
        cyc(32'h40, 0, 0, 32'h0, 0, 0, 0);
        check32("sat_then_nt_pred_f", {31'd0, bp.pred_f}, 32'd1);
        check32("sat_then_nt_target", bp.pred_target_f, 32'h80);
        cyc(32'h140, 0, 0, 32'h0, 0, 0, 0);
        check32("alias_pred_f", {31'd0, bp.pred_f}, 32'd0);
        check32("alias_target", bp.pred_target_f, 32'h144);
        cyc(32'h140, 1, 0, 32'h0, 0, 0, 0);
        cyc(32'h40, 0, 0, 32'h0, 0, 0, 0);
        check32("alias_kept_target", bp.pred_target_f, 32'h80);
        cyc(32'h40, 0, 0, 32'h0, 1, 0, 0);
        check32("stall1_pred_d", {31'd0, bp.pred_d}, 32'd1);
        cyc(32'h0, 0, 0, 32'h0, 1, 0, 0);
        check32("stall2_pred_d", {31'd0, bp.pred_d}, 32'd1);
        cyc(32'h0, 0, 0, 32'h0, 1, 0, 0);
        check32("stall3_pred_d", {31'd0, bp.pred_d}, 32'd1);
        cyc(32'h0, 0, 0, 32'h0, 1, 1, 0);
        cyc(32'h80, 0, 0, 32'h0, 0, 0, 0);
        check32("flush_pred_d", {31'd0, bp.pred_d}, 32'd0);
        cyc(32'h80, 1, 1, 32'h200, 0, 0, 1);
        cyc(32'h80, 0, 0, 32'h0, 0, 0, 0);
        check32("reset_drop_pred_f", {31'd0, bp.pred_f}, 32'd0);
        check32("reset_drop_target", bp.pred_target_f, 32'h84);
        cyc(32'h40, 0, 0, 32'h0, 0, 0, 0);
        check32("reset_clears_pred_f", {31'd0, bp.pred_f}, 32'd0);
`endif

        for (int n = 0; n < 4000; n++) begin
            cyc({$urandom_range(0, 255), 16'h0} | ($urandom_range(0, 3) << (IB + 2))
                    | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3),
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) < 6,
                $urandom,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 99) == 0);
        end
        cyc(32'h0, 0, 0, 32'h0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage dynamic branch predictor for the five-stage MIPS pipeline. Combines a direct-mapped table of 2-bit saturating counters with a tagged branch-target store. Predicts direction and target for `pc_f`, carries the prediction into Decode as `pred_d` for the controller's misprediction check, and trains on the resolved outcome when the controller raises `update_en`.

## Interface
Parameters:
- `INDEX_BITS`, default 6: table has 2^INDEX_BITS entries.
- `TAG_BITS`, default 8: tag width per entry.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `pc_f`, input, 32: fetch PC.
- `pred_f`, output, 1: predict taken (combinational).
- `pred_target_f`, output, 32: predicted next PC (combinational).
- `stall_d`, input, 1: hold the F→D prediction register.
- `flush_d`, input, 1: clear the F→D prediction register. Driven by controller `reset_d`.
- `pred_d`, output, 1: registered prediction of the instruction in Decode.
- `update_en`, input, 1: train the entry of the Decode branch.
- `taken_d`, input, 1: resolved direction (`pc_src_d`).
- `target_d`, input, 32: resolved branch target.

## Operation
**Addressing**
- Index: `idx_f = pc_f[INDEX_BITS+1:2]`.
- Tag: `tag_f = pc_f[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]`.

**Entry contents**
- valid, 1 bit.
- tag, TAG_BITS.
- ctr, 2 bits: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- target, 32 bits.

**Lookup**
- `hit = valid & (tag == tag_f)`.
- `pred_f = hit & ctr[1]`.
- `pred_target_f = pred_f ? target : pc_f + 4`. Modulo-2^32 arithmetic.

**F→D register** holds `pred`, `idx`, `tag`.
- Priority: reset > `flush_d` > `stall_d` > load.
- `flush_d` and reset both write 0 to all three fields.

**Update** uses `idx_d` and `tag_d`. Applied at the edge where `update_en=1`:
- Hit, taken: ctr saturating +1 (11 stays 11), target ← `target_d`.
- Hit, not taken: ctr saturating −1 (00 stays 00). Target unchanged.
- Miss, taken: allocate. valid←1, tag←`tag_d`, ctr←10, target←`target_d`.
- Miss, not taken: no change.
- `update_en=0`: table untouched, regardless of `taken_d`.

**Reset:** every entry valid=0, ctr=01, tag=0, target=0. `pred_d`=0, `idx_d`/`tag_d`=0. Reset during an update: reset wins and the update is dropped.

## Timing
- Lookup is zero-latency. `pred_f`/`pred_target_f` depend only on `pc_f` and table state.
- `pred_d` is valid one cycle after the fetch that produced it. It is held while `stall_d=1`.
- Training is visible to lookups from the cycle after the `update_en` edge.
- Same-cycle lookup and update of the same entry: lookup sees the pre-update state. No bypass.
- `flush_d` and `stall_d` both high: flush wins and `pred_d`=0 the next cycle.
- `update_en` is sampled with `idx_d`/`tag_d` from before the edge. A simultaneous F→D load does not affect which entry trains.

## Configuration
- Macro `BRANCH_PREDICTOR_GSHARE_EN`.
- **Defined:** adds an INDEX_BITS-wide global history register `ghr`, reset to 0.
  - `idx_f = pc_f[INDEX_BITS+1:2] ^ ghr`. Tag unchanged.
  - On each `update_en` edge: `ghr ← {ghr[INDEX_BITS-2:0], taken_d}`.
  - Training uses the captured `idx_d`, never a recomputed index.
- **Undefined:** no `ghr`. Indexing is purely PC bits. Behaviour is exactly as in Operation.

## Test plan
All scenarios use INDEX_BITS=6, TAG_BITS=8, macro undefined unless stated.
1. After reset, `pc_f`=0x40: `pred_f`=0, `pred_target_f`=0x44. Next cycle `pred_d`=0.
2. Fetch 0x40 into D. `update_en`=1, `taken_d`=1, `target_d`=0x80. Next lookup of 0x40: `pred_f`=1, `pred_target_f`=0x80 (ctr=10).
3. From ctr=10: two not-taken updates give `pred_f`=0 (ctr 00). Four taken updates saturate at 11. One not-taken update leaves `pred_f`=1 (ctr 10).
4. After training 0x40 taken, fetch 0x140 (same index, different tag): `pred_f`=0, `pred_target_f`=0x144. Then a not-taken update on 0x140 leaves the 0x40 entry predicting 0x80.
5. Fetch 0x40 (`pred_f`=1) with `stall_d`=1 for 3 cycles: `pred_d` holds. Then assert `flush_d` and `stall_d` together: `pred_d`=0 next cycle. Reset asserted with `update_en`=1: entry stays invalid.
6. Macro defined: train 0x40 taken with `ghr`=0 → entry 16 allocated, `ghr`=000001. Fetch 0x40 again: index 17, `pred_f`=0. `ghr` unchanged when `update_en`=0.
